optical_tx_framer: RTL and testbench
====================================

Name: optical_tx_framer

Overview:
Transmit-side framer for the optical link. It accepts one byte per frame over a valid/ready handshake and serialises it onto the LED drive output. The frame is a start bit, 8 data bits LSB first, an optional even-parity bit, and stop bit(s). Each bit is held for a programmable number of system clocks, matching the receiver's slow bit-rate timing. Sits between the transmit data source (keypad/FSM/FIFO) and the LED driver pin.

Parameters:
BIT_CYCLES, 2700000, system clocks per transmitted bit; must be >= 2.
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit.
STOP_BITS, 1, number of stop-bit periods (1 or 2).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  8  byte to transmit; sampled only on handshake
data_valid  input  1  source has a byte on data_in
data_ready  output  1  framer can accept a byte (high only in IDLE)
led_out  output  1  LED drive; 1 = LED on, 0 = LED off
busy  output  1  high while a frame is in progress (any state except IDLE)
tx_done  output  1  one-cycle pulse when the last stop-bit period completes

Behaviour:
- Clock/reset: clock clock; reset reset, synchronous, active-high.
- Reset values: led_out=0, data_ready=1, busy=0, tx_done=0; state=IDLE; bit-cycle counter=0; bit index=0.
- Reset mid-frame: on the next edge led_out=0 and state=IDLE. The byte in flight is discarded and tx_done is not pulsed.
- Idle line level is 0 (LED off). The start bit is 1 and stop bits are 0.
- States: IDLE -> START -> DATA(x8) -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Handshake: a transfer occurs on an edge where data_valid && data_ready.
  - data_in is latched into the shift register on that edge.
  - Parity is computed as the XOR of all 8 data bits, so total ones in data+parity is even.
  - The state moves to START and data_ready drops on the same edge.
  - data_valid and data_in are ignored while busy.
- Timing: led_out is registered.
  - The first START cycle is the edge after acceptance.
  - Each bit holds led_out for exactly BIT_CYCLES clocks.
  - The counter runs 0..BIT_CYCLES-1, width $clog2(BIT_CYCLES). On terminal count it wraps to 0 and advances the bit or state.
  - DATA sends bit 0 first; the bit index runs 0..7.
  - STOP lasts STOP_BITS*BIT_CYCLES clocks.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*BIT_CYCLES clocks of busy=1.
- End of frame: on the edge ending the last STOP cycle, state=IDLE, data_ready=1, busy=0, and tx_done=1 for that one cycle.
- Back-to-back frames: if data_valid is high in the first IDLE cycle, the byte is accepted immediately. The minimum inter-frame gap is 1 clock at led_out=0.
- No combinational path from data_valid to any output.

Test Plan:
1. BIT_CYCLES=4, PARITY_EN=1, STOP_BITS=1; reset, then send 0xA5.
   - Required: led_out = 1 for 4 clocks (start), then data bits 1,0,1,0,0,1,0,1 for 4 clocks each, then parity 0 for 4 clocks, then stop 0 for 4 clocks.
   - busy=1 for exactly 44 clocks; tx_done pulses once on the 44th edge; data_ready returns to 1.
2. Same configuration, send 0x07.
   - Required: parity bit = 1; data bits 1,1,1,0,0,0,0,0.
3. PARITY_EN=0, STOP_BITS=2, send 0xFF.
   - Required: start + 8 ones = 36 clocks high, then 8 clocks low; total busy = 44 clocks.
4. Hold data_valid=1 continuously with data_in=0x3C, then 0xC3.
   - Required: two frames with exactly 1 idle clock between them.
   - Changing data_in mid-frame does not alter the bits being sent.
5. Assert reset during DATA bit 3 of a 0xA5 frame.
   - Required: next edge led_out=0, busy=0, data_ready=1, and no tx_done pulse.
   - A following 0x5A frame transmits correctly.
6. Drive data_valid=1 while busy.
   - Required: no acceptance, and data_ready stays 0 until the end of the frame.

Source files
------------

// File: rtl/optical_tx_framer.sv
// Transmit framer for the optical link: start bit (1), 8 data bits LSB first,
// optional even parity, then STOP_BITS low stop periods. Each bit lasts BIT_CYCLES clocks.
module optical_tx_framer #(
  parameter int BIT_CYCLES = 2700000,
  parameter int PARITY_EN  = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       led_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int              CNT_W     = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2:0]         r_index;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_led;
  logic               r_busy;
  logic               r_ready;
  logic               r_done;
  logic               w_bit_end;

  assign w_bit_end  = (r_count == CNT_LAST);
  assign led_out    = r_led;
  assign busy       = r_busy;
  assign data_ready = r_ready;
  assign tx_done    = r_done;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_index  <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_led    <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_count <= w_bit_end ? '0 : r_count + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (data_valid && r_ready) begin
            r_shift  <= data_in;
            r_parity <= ^data_in;
            r_count  <= '0;
            r_state  <= S_START;
            r_led    <= 1'b1;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_index <= '0;
            r_led   <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_index == 3'd7) begin
              r_index <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_led   <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_led   <= 1'b0;
              end
            end else begin
              r_index <= r_index + 3'd1;
              r_led   <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_index <= '0;
            r_led   <= 1'b0;
          end
        end

        S_STOP: begin
          // r_index counts stop periods so two stop bits need no second counter.
          if (w_bit_end) begin
            if (r_index == STOP_LAST) begin
              r_state <= S_IDLE;
              r_index <= '0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_index <= r_index + 3'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_optical_tx_framer.sv
// Bench for optical_tx_framer: two instances (parity/1 stop and no parity/2 stop)
// checked cycle by cycle against a reference LED waveform built from the frame format.
module tb_optical_tx_framer;

  localparam int BC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_a = 8'h00, din_b = 8'h00;
  logic       dv_a = 1'b0, dv_b = 1'b0;
  logic       led_a, led_b, busy_a, busy_b, rdy_a, rdy_b, done_a, done_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  optical_tx_framer #(.BIT_CYCLES(BC), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .data_in(din_a), .data_valid(dv_a),
    .data_ready(rdy_a), .led_out(led_a), .busy(busy_a), .tx_done(done_a)
  );

  optical_tx_framer #(.BIT_CYCLES(BC), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset(reset), .data_in(din_b), .data_valid(dv_b),
    .data_ready(rdy_b), .led_out(led_b), .busy(busy_b), .tx_done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_led(input bit s);  return s ? led_b  : led_a;  endfunction
  function automatic logic get_busy(input bit s); return s ? busy_b : busy_a; endfunction
  function automatic logic get_rdy(input bit s);  return s ? rdy_b  : rdy_a;  endfunction
  function automatic logic get_done(input bit s); return s ? done_b : done_a; endfunction

  task automatic drive(input bit s, input logic v, input logic [7:0] d);
    if (s) begin dv_b = v; din_b = d; end
    else   begin dv_a = v; din_a = d; end
  endtask

  // Checks both instances are quiet for n cycles.
  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(negedge clock);
      for (int s = 0; s < 2; s++) begin
        check($sformatf("%s_led%0d", tag, s),  32'(get_led(s[0])),  32'd0);
        check($sformatf("%s_busy%0d", tag, s), 32'(get_busy(s[0])), 32'd0);
        check($sformatf("%s_rdy%0d", tag, s),  32'(get_rdy(s[0])),  32'd1);
        check($sformatf("%s_done%0d", tag, s), 32'(get_done(s[0])), 32'd0);
      end
    end
  endtask

  // Sends one byte and checks the whole waveform. keep holds data_valid high with
  // data_in = nxt after acceptance; abort_at >= 0 pulses reset on that frame cycle.
  task automatic send_frame(input bit s, input logic [7:0] b, input bit keep,
                            input logic [7:0] nxt, input int abort_at);
    bit    exp_q[$];
    int    pe, sb;
    string tag;
    pe  = s ? 0 : 1;
    sb  = s ? 2 : 1;
    tag = $sformatf("%s_%02h", s ? "B" : "A", b);
    for (int c = 0; c < BC; c++) exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < BC; c++) exp_q.push_back(b[i]);
    if (pe != 0)
      for (int c = 0; c < BC; c++) exp_q.push_back(^b);
    for (int c = 0; c < sb * BC; c++) exp_q.push_back(1'b0);

    check({tag, "_ready_pre"}, 32'(get_rdy(s)), 32'd1);
    drive(s, 1'b1, b);
    @(posedge clock);
    #1;
    drive(s, keep, keep ? nxt : 8'($urandom));

    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      check($sformatf("%s_led_c%0d", tag, k),  32'(get_led(s)),  32'(exp_q[k]));
      check($sformatf("%s_busy_c%0d", tag, k), 32'(get_busy(s)), 32'd1);
      check($sformatf("%s_rdy_c%0d", tag, k),  32'(get_rdy(s)),  32'd0);
      check($sformatf("%s_done_c%0d", tag, k), 32'(get_done(s)), 32'd0);
      if (k == abort_at) begin
        reset = 1'b1;
        drive(s, 1'b0, 8'h00);
        @(negedge clock);
        check({tag, "_rst_led"},  32'(get_led(s)),  32'd0);
        check({tag, "_rst_busy"}, 32'(get_busy(s)), 32'd0);
        check({tag, "_rst_rdy"},  32'(get_rdy(s)),  32'd1);
        check({tag, "_rst_done"}, 32'(get_done(s)), 32'd0);
        reset = 1'b0;
        return;
      end
    end

    @(negedge clock);
    check({tag, "_end_done"}, 32'(get_done(s)), 32'd1);
    check({tag, "_end_busy"}, 32'(get_busy(s)), 32'd0);
    check({tag, "_end_rdy"},  32'(get_rdy(s)),  32'd1);
    check({tag, "_end_led"},  32'(get_led(s)),  32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(2, "reset");

    send_frame(1'b0, 8'hA5, 1'b0, 8'h00, -1);   // parity 0
    idle(1, "gap1");
    send_frame(1'b0, 8'h07, 1'b0, 8'h00, -1);   // parity 1
    idle(1, "gap2");
    send_frame(1'b1, 8'hFF, 1'b0, 8'h00, -1);   // no parity, two stop bits
    idle(1, "gap3");

    // Back-to-back with data_valid held; data_in changes mid-frame.
    send_frame(1'b0, 8'h3C, 1'b1, 8'hC3, -1);
    send_frame(1'b0, 8'hC3, 1'b0, 8'h00, -1);
    idle(2, "gap4");
    send_frame(1'b1, 8'h3C, 1'b1, 8'hC3, -1);
    send_frame(1'b1, 8'hC3, 1'b0, 8'h00, -1);
    idle(1, "gap5");

    // Reset during DATA bit 3 (frame cycles 16..19).
    send_frame(1'b0, 8'hA5, 1'b0, 8'h00, 17);
    idle(50, "post_rst");
    send_frame(1'b0, 8'h5A, 1'b0, 8'h00, -1);

    for (int n = 0; n < 24; n++) begin
      idle($urandom_range(0, 3), "rnd_gap");
      send_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'h00, -1);
    end
    idle(2, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
